// File: rtl/trainled_chain_n.sv
// -----------------------------------------------------------------------------
// trainled_chain_n
//
// Daisy-chained PWM LED node. A pulse-width-coded serial stream arrives on
// din: every high pulse carries one bit, and its width decides the value.
// Pulses of T_THRESH clk cycles or longer decode as '1'. Shorter pulses,
// including a single-cycle pulse, decode as '0'. A low period of T_IDLE clk
// cycles ends the frame.
//
// The node keeps the first NUM_CH*PWM_W bits of a frame as its duty values.
// Bits arrive MSB first, channel 0 first. Every later pulse is passed on
// unchanged on dout to the next node, three clk cycles after it appears on
// din. Duty values are committed only at the end of a complete frame.
// frame_strobe pulses for one cycle when that happens. A partial frame is
// dropped and does not change the duties.
//
// Optional feature (compile-time macro TRAINLED_GAMMA_EN):
//   When the macro is defined, each duty passes through a 2.0 gamma curve at
//   latch time: (d*d) >> PWM_W. Full scale stays full scale, and a nonzero
//   duty never collapses to zero. When the macro is undefined, the duty is
//   used as received and no multiplier exists.
//
// Parameters:
//   NUM_CH   number of LED channels (1..8)
//   PWM_W    duty / PWM counter width (4..12)
//   T_THRESH high-time in clk cycles at or above which a pulse is a '1'
//   T_IDLE   low-time in clk cycles that ends a frame (> T_THRESH)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   din          serial chain input (asynchronous to clk, idles low)
//   dout         serial chain output to the next node
//   led          PWM outputs, led[i] is channel i
//   frame_strobe one-cycle pulse when new duties are latched
// -----------------------------------------------------------------------------
module trainled_chain_n #(
  parameter int NUM_CH   = 3,
  parameter int PWM_W    = 8,
  parameter int T_THRESH = 8,
  parameter int T_IDLE   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic              dout,
  output logic [NUM_CH-1:0] led,
  output logic              frame_strobe
);

  localparam int FRAME_W = NUM_CH * PWM_W;
  localparam int HC_W    = $clog2(T_THRESH + 1);
  localparam int LC_W    = $clog2(T_IDLE + 1);
  localparam int BC_W    = $clog2(FRAME_W + 1);

  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(T_THRESH);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(T_IDLE);
  localparam logic [LC_W-1:0] LC_PRE  = LC_W'(T_IDLE - 1);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_FORWARD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Duty shaping applied at latch time
  // ---------------------------------------------------------------------------
`ifdef TRAINLED_GAMMA_EN
  function automatic logic [PWM_W-1:0] shape(input logic [PWM_W-1:0] d);
    logic [2*PWM_W-1:0] sq;
    logic [PWM_W-1:0]   r;
    sq = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d};
    r  = sq[2*PWM_W-1:PWM_W];
    // Full scale must stay full scale. A dim but nonzero request must not
    // turn the LED off.
    if (d == {PWM_W{1'b1}}) begin
      r = {PWM_W{1'b1}};
    end else if ((d != '0) && (r == '0)) begin
      r = PWM_W'(1);
    end
    return r;
  endfunction
`else
  function automatic logic [PWM_W-1:0] shape(input logic [PWM_W-1:0] d);
    return d;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic sync1;
  logic din_s;
  logic din_d;
  logic fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      sync1 <= din;
      din_s <= sync1;
      din_d <= din_s;
    end
  end

  assign fall = din_d & ~din_s;

  // ---------------------------------------------------------------------------
  // Pulse timers
  // ---------------------------------------------------------------------------
  logic [HC_W-1:0] high_cnt;
  logic [LC_W-1:0] low_cnt;
  logic            bit_val;
  logic            idle_evt;

  // high_cnt only needs to tell "at least T_THRESH" apart from "less".
  // Saturating at T_THRESH keeps a stuck-high line from wrapping back into
  // the '0' range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cnt <= '0;
    end else if (fall) begin
      high_cnt <= '0;
    end else if (din_s && (high_cnt != HC_MAX)) begin
      high_cnt <= high_cnt + HC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cnt <= '0;
    end else if (din_s) begin
      low_cnt <= '0;
    end else if (low_cnt != LC_MAX) begin
      low_cnt <= low_cnt + LC_W'(1);
    end
  end

  assign bit_val = (high_cnt >= HC_MAX);

  // This fires on the edge that moves low_cnt onto T_IDLE. Saturation then
  // holds the counter there, so each low period produces exactly one idle
  // event.
  assign idle_evt = ~din_s && (low_cnt == LC_PRE);

  // ---------------------------------------------------------------------------
  // Frame state machine
  // ---------------------------------------------------------------------------
  state_t              state_q;
  state_t              state_d;
  logic [BC_W-1:0]     bit_cnt_q;
  logic [BC_W-1:0]     bit_cnt_d;
  logic                shift_en;
  logic                load_en;
  logic [FRAME_W-1:0]  shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    if (idle_evt) begin
      // Only a frame that reached FORWARD holds a full set of duties.
      load_en   = (state_q == ST_FORWARD);
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          shift_en  = 1'b1;
          bit_cnt_d = BC_ONE;
          state_d   = ST_RECEIVE;
        end
        ST_RECEIVE: begin
          shift_en  = 1'b1;
          bit_cnt_d = bit_cnt_q + BC_ONE;
          if (bit_cnt_q == BC_LAST) begin
            state_d = ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          // Later pulses are passed on, not decoded.
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[FRAME_W-2:0], bit_val};
    end
  end

  // dout follows din_d, so a forwarded pulse keeps its width and trails din
  // by three clk cycles. The last consumed pulse has already fallen by the
  // time FORWARD begins, so none of it leaks onto dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 1'b0;
    end else begin
      dout <= (state_q == ST_FORWARD) ? din_d : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= load_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty registers: channel 0 takes the oldest (top) PWM_W bits
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] raw_duty [NUM_CH];
  logic [PWM_W-1:0] eff_next [NUM_CH];
  logic [PWM_W-1:0] duty_eff [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign raw_duty[g] = shift_q[(NUM_CH-1-g)*PWM_W +: PWM_W];
    assign eff_next[g] = shape(raw_duty[g]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_eff[i] <= '0;
      end
    end else if (load_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_eff[i] <= eff_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PWM generation
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] pwm_cnt;

  // New duties are compared straight away rather than at the counter wrap.
  // One period can therefore show a mix of the old and new duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      for (int i = 0; i < NUM_CH; i++) begin
        led[i] <= (duty_eff[i] > pwm_cnt);
      end
    end
  end

endmodule

// File: tb/tb_trainled_chain_n.sv
// -----------------------------------------------------------------------------
// tb_trainled_chain_n
//
// Directed bench for trainled_chain_n with the default parameters.
//
// The bench model records three things as the stimulus is driven:
//   - which input cycles carry forwarded pulses (hist_fwd),
//   - when each complete frame must strobe (strobe_edge),
//   - the duties that the strobe commits (pend_duty).
//
// A compare process checks dout, frame_strobe and led against the model on
// every cycle after reset. Literal checks on strobe counts, dout high-cycle
// totals and 256-cycle led on-times pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_trainled_chain_n;

  localparam int NUM_CH   = 3;
  localparam int PWM_W    = 8;
  localparam int T_THRESH = 8;
  localparam int T_IDLE   = 64;
  localparam int FRAME_W  = NUM_CH * PWM_W;
  localparam int HI0      = 3;
  localparam int HI1      = 10;
  localparam int LO       = 6;
  localparam int MAXC     = 16384;

  // Clock / reset
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              din = 1'b0;
  logic              dout;
  logic [NUM_CH-1:0] led;
  logic              frame_strobe;

  trainled_chain_n #(
    .NUM_CH   (NUM_CH),
    .PWM_W    (PWM_W),
    .T_THRESH (T_THRESH),
    .T_IDLE   (T_IDLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .dout         (dout),
    .led          (led),
    .frame_strobe (frame_strobe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  int               n_cmp = 0;
  int               n_fail = 0;
  bit               hist_fwd [MAXC];
  int               strobe_edge = -1;
  int               rel_cyc = 0;
  logic [PWM_W-1:0] model_duty [NUM_CH];
  logic [PWM_W-1:0] pend_duty [NUM_CH];
  int               frame_bits = 0;
  bit               fbits [$];
  int               last_set = 0;
  int               last_fall = 0;
  int               strobe_seen = 0;
  int               dout_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Effective duty for a received value, taken from the gamma rule.
  function automatic logic [PWM_W-1:0] eff(input logic [PWM_W-1:0] d);
`ifdef TRAINLED_GAMMA_EN
    int sq;
    sq = (int'(d) * int'(d)) >> PWM_W;
    if (d == {PWM_W{1'b1}}) return d;
    if ((d != '0) && (sq == 0)) return PWM_W'(1);
    return PWM_W'(sq);
`else
    return d;
`endif
  endfunction

  // Compare process. led after edge m must equal duty > (PWM phase of edge
  // m-1), where the phase counts edges since reset release. dout must repeat
  // the forwarded input from three edges earlier.
  always @(negedge clk) begin : compare
    logic [NUM_CH-1:0] exp_l;
    logic [PWM_W-1:0]  ph;
    bit                exp_d;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) model_duty[i] = '0;
    end else if (cyc > rel_cyc) begin
      ph = PWM_W'(cyc - 1 - rel_cyc);
      for (int i = 0; i < NUM_CH; i++) exp_l[i] = (model_duty[i] > ph);
      exp_d = ((cyc >= 3) && (cyc - 3 < MAXC)) ? hist_fwd[cyc-3] : 1'b0;
      check("led", 32'(led), 32'(exp_l));
      check("dout", 32'(dout), 32'(exp_d));
      check("frame_strobe", 32'(frame_strobe), (cyc == strobe_edge) ? 32'd1 : 32'd0);
      if (cyc == strobe_edge) begin
        for (int i = 0; i < NUM_CH; i++) model_duty[i] = pend_duty[i];
      end
    end
  end

  // Driver tasks
  task automatic drive(input bit v, input bit fwd);
    @(posedge clk);
    #1;
    din = v;
    last_set = cyc + 1;
    if (last_set < MAXC) hist_fwd[last_set] = fwd & v;
    @(negedge clk);
    if (frame_strobe) strobe_seen++;
    if (dout) dout_seen++;
  endtask

  task automatic send(input bit b, input int hi);
    bit fwd;
    fwd = (frame_bits >= FRAME_W);
    if (!fwd) fbits.push_back(b);
    frame_bits++;
    repeat (hi) drive(1'b1, fwd);
    drive(1'b0, fwd);
    last_fall = last_set;
    repeat (LO - 1) drive(1'b0, fwd);
  endtask

  task automatic send_byte(input logic [7:0] v, input int hi0, input int hi1);
    for (int k = 7; k >= 0; k--) send(v[k], v[k] ? hi1 : hi0);
  endtask

  task automatic end_frame(input int idle);
    logic [PWM_W-1:0] v;
    if (frame_bits >= FRAME_W) begin
      for (int c = 0; c < NUM_CH; c++) begin
        v = '0;
        for (int k = 0; k < PWM_W; k++) v = {v[PWM_W-2:0], fbits[c*PWM_W+k]};
        pend_duty[c] = eff(v);
      end
      // din is first sampled low at last_fall. Two synchroniser stages
      // follow, then T_IDLE counted low cycles.
      strobe_edge = last_fall + 1 + T_IDLE;
    end
    repeat (idle) drive(1'b0, 1'b0);
    frame_bits = 0;
    fbits.delete();
  endtask

  task automatic clear_counts();
    strobe_seen = 0;
    dout_seen = 0;
  endtask

  task automatic measure(input string tag, input int e0, input int e1, input int e2);
    int ones [NUM_CH];
    for (int i = 0; i < NUM_CH; i++) ones[i] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) if (led[i]) ones[i]++;
    end
    check({tag, " led0 on-cycles"}, ones[0], e0);
    check({tag, " led1 on-cycles"}, ones[1], e1);
    check({tag, " led2 on-cycles"}, ones[2], e2);
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset led", 32'(led), 32'd0);
    check("async reset dout", 32'(dout), 32'd0);
    repeat (ncyc) begin
      @(negedge clk);
      check("reset led", 32'(led), 32'd0);
      check("reset dout", 32'(dout), 32'd0);
      check("reset frame_strobe", 32'(frame_strobe), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    frame_bits = 0;
    fbits.delete();
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: run did not complete within time limit");
    finish_run();
  end

  initial begin : stimulus
    #1;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset led", 32'(led), 32'd0);
      check("reset dout", 32'(dout), 32'd0);
      check("reset frame_strobe", 32'(frame_strobe), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    repeat (4) drive(1'b0, 1'b0);

    // Basic frame: full, half and zero duty, nothing forwarded.
    clear_counts();
    send_byte(8'hFF, HI0, HI1);
    send_byte(8'h80, HI0, HI1);
    send_byte(8'h00, HI0, HI1);
    end_frame(80);
    check("t1 strobe count", strobe_seen, 1);
    check("t1 dout high cycles", dout_seen, 0);
    check("t1 model duty0", 32'(model_duty[0]), 32'(eff(8'hFF)));
    measure("t1", eff(8'hFF), eff(8'h80), eff(8'h00));

    // Double-length frame: the second 24 pulses are forwarded unchanged.
    clear_counts();
    send_byte(8'h10, HI0, HI1);
    send_byte(8'h20, HI0, HI1);
    send_byte(8'h30, HI0, HI1);
    send_byte(8'hAA, HI0, HI1);
    send_byte(8'h55, HI0, HI1);
    send_byte(8'h0F, HI0, HI1);
    end_frame(80);
    check("t2 strobe count", strobe_seen, 1);
    check("t2 dout high cycles", dout_seen, 12 * HI1 + 12 * HI0);
    measure("t2", eff(8'h10), eff(8'h20), eff(8'h30));

    // Partial frame is dropped, then a full frame latches normally.
    clear_counts();
    send_byte(8'hFF, HI0, HI1);
    send(1'b1, HI1);
    send(1'b1, HI1);
    end_frame(80);
    check("t3 partial strobe count", strobe_seen, 0);
    measure("t3 partial", eff(8'h10), eff(8'h20), eff(8'h30));
    clear_counts();
    send_byte(8'h40, HI0, HI1);
    send_byte(8'h08, HI0, HI1);
    send_byte(8'hC0, HI0, HI1);
    end_frame(80);
    check("t3 full strobe count", strobe_seen, 1);
    measure("t3 full", eff(8'h40), eff(8'h08), eff(8'hC0));

    // Threshold: 7-cycle pulses decode as '0' and 8-cycle pulses as '1'.
    // Channel 2 uses 1-cycle pulses for its zeros.
    clear_counts();
    send_byte(8'h55, T_THRESH - 1, T_THRESH);
    send_byte(8'h0F, T_THRESH - 1, T_THRESH);
    send_byte(8'hF0, 1, T_THRESH);
    end_frame(80);
    check("t4 strobe count", strobe_seen, 1);
    check("t4 model duty0", 32'(model_duty[0]), 32'(eff(8'h55)));
    measure("t4", eff(8'h55), eff(8'h0F), eff(8'hF0));

    // Stuck high for 300 cycles: no latch while high, then a single '1'.
    clear_counts();
    send(1'b1, 300);
    for (int k = 0; k < 7; k++) send(1'b0, HI0);
    send_byte(8'h11, HI0, HI1);
    send_byte(8'h22, HI0, HI1);
    end_frame(80);
    check("t5 strobe count", strobe_seen, 1);
    measure("t5", eff(8'h80), eff(8'h11), eff(8'h22));

    // Reset mid-frame, then a fresh frame.
    clear_counts();
    send_byte(8'hAB, HI0, HI1);
    for (int k = 0; k < 4; k++) send(k < 2, (k < 2) ? HI1 : HI0);
    do_reset(4);
    repeat (4) drive(1'b0, 1'b0);
    send_byte(8'h01, HI0, HI1);
    send_byte(8'h02, HI0, HI1);
    send_byte(8'h03, HI0, HI1);
    end_frame(80);
    check("t6 strobe count", strobe_seen, 1);
    measure("t6", eff(8'h01), eff(8'h02), eff(8'h03));

    // Gamma corner values.
    clear_counts();
    send_byte(8'h80, HI0, HI1);
    send_byte(8'hFF, HI0, HI1);
    send_byte(8'h01, HI0, HI1);
    end_frame(80);
    check("t7 strobe count", strobe_seen, 1);
`ifdef TRAINLED_GAMMA_EN
    check("t7 model duty0", 32'(model_duty[0]), 32'h40);
    measure("t7", 8'h40, 8'hFF, 8'h01);
`else
    check("t7 model duty0", 32'(model_duty[0]), 32'h80);
    measure("t7", 8'h80, 8'hFF, 8'h01);
`endif

    finish_run();
  end

endmodule
